stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller producing the 100 Hz count enable, core clear and display mux.
// Define STOPWATCH_CTRL_LAP_EN to build the LAP state and snapshot registers; otherwise the display is always live.
module stopwatch_ctrl #(
    parameter int unsigned time_scale = 500000
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic       ss_i,
    input  logic       lc_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    input  logic [6:0] ms_10_i,
    output logic       tick_en,
    output logic       core_clr_n,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec,
    output logic [6:0] disp_ms_10,
    output logic [1:0] state_o
);
    localparam int unsigned PW = (time_scale > 1) ? $clog2(time_scale) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(time_scale - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] ms_10;
    } disp_t;

    state_e        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic          ss_q, lc_q;
    logic          tick_q, tick_d;
    logic          clr_n_q, clr_n_d;
    disp_t         disp_q, disp_d;
    disp_t         live;
    logic          ss_press, lc_press;

    assign live = '{min: min_i, sec: sec_i, ms_10: ms_10_i};

`ifdef STOPWATCH_CTRL_LAP_EN
    disp_t snap_q, snap_d;
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        ss_press = ss_i & ~ss_q;
        lc_press = lc_i & ~lc_q;
        state_d  = state_q;

        case (state_q)
            IDLE: if (ss_press) state_d = RUN;
            RUN: begin
                if (ss_press) state_d = PAUSE;
`ifdef STOPWATCH_CTRL_LAP_EN
                else if (lc_press) state_d = LAP;
`endif
            end
            PAUSE: begin
                if (ss_press)      state_d = RUN;
                else if (lc_press) state_d = IDLE;
            end
`ifdef STOPWATCH_CTRL_LAP_EN
            LAP: begin
                if (ss_press)      state_d = PAUSE;
                else if (lc_press) state_d = RUN;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Phase is held through PAUSE so a pause/resume pair costs no tick phase.
        p_d    = p_q;
        tick_d = 1'b0;
        case (state_q)
            RUN, LAP: begin
                if (p_q == P_MAX) begin
                    p_d    = '0;
                    tick_d = 1'b1;
                end else begin
                    p_d = p_q + PW'(1);
                end
            end
            PAUSE:   p_d = p_q;
            default: p_d = '0;
        endcase

        clr_n_d = ~((state_q == PAUSE) && (state_d == IDLE));

`ifdef STOPWATCH_CTRL_LAP_EN
        snap_d = ((state_q == RUN) && (state_d == LAP)) ? live : snap_q;
        disp_d = (state_d == LAP) ? snap_d : live;
`else
        disp_d = live;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset value of
    // the button history is 1 so a button held through reset never reads as a press.
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            ss_q    <= 1'b1;
            lc_q    <= 1'b1;
            tick_q  <= 1'b0;
            clr_n_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            ss_q    <= ss_i;
            lc_q    <= lc_i;
            tick_q  <= tick_d;
            clr_n_q <= clr_n_d;
            disp_q  <= disp_d;
        end
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) snap_q <= '0;
        else      snap_q <= snap_d;
    end
`endif

    assign tick_en    = tick_q;
    assign core_clr_n = clr_n_q;
    assign disp_min   = disp_q.min;
    assign disp_sec   = disp_q.sec;
    assign disp_ms_10 = disp_q.ms_10;
    assign state_o    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with time_scale = 4 and a small counter-core model.
// Expectations are queued per cycle by the stimulus; one monitor compares them on each falling edge.
module tb_stopwatch_ctrl;
    localparam int TS = 4;

`ifdef STOPWATCH_CTRL_LAP_EN
    localparam int LC_ST = 3;
`else
    localparam int LC_ST = 1;
`endif

    typedef enum int {K_STATE, K_CLR, K_TICK, K_MIN, K_SEC, K_MS} kind_e;
    typedef struct {
        int    cyc;
        kind_e kind;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   tick_q[$];
    exp_t e;
    bit   exp_tick;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_tick = 0;
    int   rem = 0;

    logic       clk_core = 1'b0;
    logic       rst = 1'b0;
    logic       ss_i = 1'b1;
    logic       lc_i = 1'b0;
    logic [5:0] min_i, sec_i;
    logic [6:0] ms_10_i;
    logic       tick_en, core_clr_n;
    logic [5:0] disp_min, disp_sec;
    logic [6:0] disp_ms_10;
    logic [1:0] state_o;

    logic       preset_req = 1'b0;
    logic [5:0] pre_min = '0, pre_sec = '0;
    logic [6:0] pre_ms = '0;

    stopwatch_ctrl #(.time_scale(TS)) dut (
        .clk_core  (clk_core),
        .rst       (rst),
        .ss_i      (ss_i),
        .lc_i      (lc_i),
        .min_i     (min_i),
        .sec_i     (sec_i),
        .ms_10_i   (ms_10_i),
        .tick_en   (tick_en),
        .core_clr_n(core_clr_n),
        .disp_min  (disp_min),
        .disp_sec  (disp_sec),
        .disp_ms_10(disp_ms_10),
        .state_o   (state_o)
    );

    always #5 clk_core = ~clk_core;

    always @(posedge clk_core) cyc <= cyc + 1;

    // Counter core: clears on core_clr_n, loads presets, counts on tick_en with wrap at 59:59.99.
    always @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            min_i <= '0; sec_i <= '0; ms_10_i <= '0;
        end else if (!core_clr_n) begin
            min_i <= '0; sec_i <= '0; ms_10_i <= '0;
        end else if (preset_req) begin
            min_i <= pre_min; sec_i <= pre_sec; ms_10_i <= pre_ms;
        end else if (tick_en) begin
            if (ms_10_i == 7'd99) begin
                ms_10_i <= '0;
                if (sec_i == 6'd59) begin
                    sec_i <= '0;
                    min_i <= (min_i == 6'd59) ? 6'd0 : min_i + 6'd1;
                end else begin
                    sec_i <= sec_i + 6'd1;
                end
            end else begin
                ms_10_i <= ms_10_i + 7'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    // Monitor: compares every queued expectation due this cycle and every tick_en pulse.
    always @(negedge clk_core) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_STATE: check("state_o",    32'(state_o),    32'(e.val));
                K_CLR:   check("core_clr_n", 32'(core_clr_n), 32'(e.val));
                K_TICK:  check("tick_en",    32'(tick_en),    32'(e.val));
                K_MIN:   check("disp_min",   32'(disp_min),   32'(e.val));
                K_SEC:   check("disp_sec",   32'(disp_sec),   32'(e.val));
                default: check("disp_ms_10", 32'(disp_ms_10), 32'(e.val));
            endcase
        end
        exp_tick = (tick_q.size() > 0 && tick_q[0] == cyc);
        if (exp_tick) void'(tick_q.pop_front());
        if (exp_tick || tick_en) check("tick_en_pulse", 32'(tick_en), 32'(exp_tick));
    end

    task automatic expect_at(input int dc, input kind_e k, input int v);
        exp_t x;
        x.cyc  = cyc + dc;
        x.kind = k;
        x.val  = v;
        exp_q.push_back(x);
    endtask

    task automatic expect_disp(input int dc, input int m, input int s, input int h);
        expect_at(dc, K_MIN, m);
        expect_at(dc, K_SEC, s);
        expect_at(dc, K_MS, h);
    endtask

    // Queue every tick due up to the given cycle at the fixed tick period.
    task automatic sched(input int upto);
        while (next_tick <= upto) begin
            tick_q.push_back(next_tick);
            next_tick += TS;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    task automatic go(input int n, input bit running);
        if (running) sched(cyc + n);
        step(n);
    endtask

    task automatic press(input logic s, input logic l, input int st, input bit running);
        if (running) sched(cyc + 1);
        ss_i = s;
        lc_i = l;
        expect_at(1, K_STATE, st);
        step(1);
        ss_i = 1'b0;
        lc_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset values while rst is low, with ss_i held high.
        expect_at(1, K_STATE, 0);
        expect_at(1, K_CLR, 0);
        expect_at(1, K_TICK, 0);
        expect_disp(1, 0, 0, 0);
        step(2);
        rst = 1'b1;
        expect_at(1, K_STATE, 0);
        expect_at(1, K_CLR, 1);
        step(1);
        ss_i = 1'b0;
        expect_at(2, K_STATE, 0);
        step(2);

        // Start: ticks 4, 8, 12 cycles after the transition edge.
        press(1'b1, 1'b0, 1, 1'b0);
        next_tick = cyc + TS;
        go(13, 1'b1);

        // Pause two cycles past a tick, hold, resume: next tick two cycles after resume.
        press(1'b1, 1'b0, 2, 1'b1);
        rem = next_tick - cyc;
        go(10, 1'b0);
        press(1'b1, 1'b0, 1, 1'b0);
        next_tick = cyc + rem;

`ifdef STOPWATCH_CTRL_LAP_EN
        // Lap at 00:03.41: display frozen while the core keeps counting, then live again.
        pre_min = 6'd0; pre_sec = 6'd3; pre_ms = 7'd41;
        preset_req = 1'b1;
        go(1, 1'b1);
        preset_req = 1'b0;
        go(1, 1'b1);
        expect_disp(1, 0, 3, 41);
        press(1'b0, 1'b1, 3, 1'b1);
        expect_disp(5, 0, 3, 41);
        go(5, 1'b1);
        expect_disp(1, 0, 3, 43);
        press(1'b0, 1'b1, 1, 1'b1);
        expect_disp(3, 0, 3, 44);
        go(3, 1'b1);
`else
        press(1'b0, 1'b1, 1, 1'b1);
        go(2, 1'b1);
`endif

        // Simultaneous presses in RUN: ss wins.
        press(1'b1, 1'b1, 2, 1'b1);
        rem = next_tick - cyc;
        go(3, 1'b0);

        // Clear from PAUSE: one-cycle low pulse, core and display return to zero.
        expect_at(1, K_CLR, 0);
        press(1'b0, 1'b1, 0, 1'b0);
        expect_at(1, K_CLR, 1);
        expect_disp(2, 0, 0, 0);
        go(4, 1'b0);

        // Load 12:34.56, run, lc press, then asynchronous reset just after a tick edge.
        pre_min = 6'd12; pre_sec = 6'd34; pre_ms = 7'd56;
        preset_req = 1'b1;
        go(1, 1'b0);
        preset_req = 1'b0;
        expect_disp(1, 12, 34, 56);
        go(1, 1'b0);
        press(1'b1, 1'b0, 1, 1'b0);
        next_tick = cyc + TS;
        go(1, 1'b1);
        press(1'b0, 1'b1, LC_ST, 1'b1);
        go(1, 1'b1);
        expect_at(1, K_STATE, 0);
        expect_at(1, K_CLR, 0);
        expect_at(1, K_TICK, 0);
        expect_disp(1, 0, 0, 0);
        @(posedge clk_core);
        #1 rst = 1'b0;
        step(1);
        step(2);
        rst = 1'b1;
        expect_at(1, K_CLR, 1);
        expect_at(1, K_STATE, 0);
        go(8, 1'b0);

        check("pending_expectations", 32'(exp_q.size() + tick_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
